// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the cpu_ctrl_seq multi-cycle control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_LUI   = 4'b0101;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  localparam logic [1:0] PC_4   = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  // Datapath controls fixed at decode time and held for the rest of the instruction.
  typedef struct packed {
    logic [1:0] com_format;
    logic       ext_sel;
    logic [1:0] reg_dst;
    logic       b_src;
    logic [3:0] op_sel;
    logic [1:0] wb_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Branch resolution from the opcode and the ALU zero flag.
  function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic zero);
    return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal-opcode flag.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output ctrl_t           o_ctrl_c,
  output logic            o_illegal_c
);

  // Opcode table lookup; anything not listed is flagged illegal.
  always_comb begin
    o_ctrl_c    = CTRL_NOP;
    o_illegal_c = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl_c.com_format = FMT_R;
        o_ctrl_c.op_sel     = ALU_FUNCT;
        o_ctrl_c.reg_dst    = RD_RD;
      end
      OP_LW: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_ADD;
        o_ctrl_c.b_src      = 1'b1;
        o_ctrl_c.ext_sel    = 1'b1;
        o_ctrl_c.wb_src     = WB_MEM;
      end
      OP_SW: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_ADD;
        o_ctrl_c.b_src      = 1'b1;
        o_ctrl_c.ext_sel    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_SUB;
        o_ctrl_c.ext_sel    = 1'b1;
      end
      OP_J: begin
        o_ctrl_c.com_format = FMT_J;
      end
      OP_JAL: begin
        o_ctrl_c.com_format = FMT_J;
        o_ctrl_c.reg_dst    = RD_R31;
        o_ctrl_c.wb_src     = WB_PC4;
      end
      OP_ADDI: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_ADD;
        o_ctrl_c.b_src      = 1'b1;
        o_ctrl_c.ext_sel    = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_AND;
        o_ctrl_c.b_src      = 1'b1;
      end
      OP_ORI: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_OR;
        o_ctrl_c.b_src      = 1'b1;
      end
      OP_SLTI: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_SLT;
        o_ctrl_c.b_src      = 1'b1;
        o_ctrl_c.ext_sel    = 1'b1;
      end
      OP_LUI: begin
        o_ctrl_c.com_format = FMT_I;
        o_ctrl_c.op_sel     = ALU_LUI;
        o_ctrl_c.b_src      = 1'b1;
      end
      default: o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the dataFlow datapath.
// Optional macro CPU_CTRL_PERF_EN adds perf_cycles / perf_instr counters.
// Every output is a register loaded with the value belonging to the state being entered.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          RESET_HALT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] OpCode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_en,
  output logic [1:0]      PCSrc,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            mem_req,
  output logic [1:0]      RegDst,
  output logic            ExtSel,
  output logic [3:0]      OpSel,
  output logic            BSrc,
  output logic [1:0]      WBSrc,
  output logic [1:0]      comFormat,
  output logic            halted,
  output logic            err
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_instr
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 2);

  state_e            r_state;
  logic [OP_W-1:0]   r_opcode;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_wb_sel;
  logic              r_pc_en;
  logic              r_ir_en;
  logic [1:0]        r_pc_src;
  logic              r_reg_write;
  logic              r_mem_write;
  logic              r_mem_req;
  logic [1:0]        r_reg_dst;
  logic              r_ext_sel;
  logic [3:0]        r_op_sel;
  logic              r_b_src;
  logic [1:0]        r_wb_src;
  logic [1:0]        r_com_format;
  logic              r_halted;
  logic              r_err;

  ctrl_t             w_ctrl;
  logic              w_illegal;
  logic              w_timeout_hit;

  cpu_ctrl_decode u_decode (
    .i_opcode    (OpCode),
    .o_ctrl_c    (w_ctrl),
    .o_illegal_c (w_illegal)
  );

  // Next waiting cycle would reach the limit; a zero limit never expires.
  assign w_timeout_hit = (MEM_TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) == 32'(MEM_TIMEOUT));

  // Sequencer: state register and all registered controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET_HALT ? ST_HALT : ST_FETCH;
      r_halted     <= RESET_HALT;
      r_opcode     <= '0;
      r_cnt        <= '0;
      r_wb_sel     <= WB_ALU;
      r_pc_en      <= 1'b0;
      r_ir_en      <= 1'b0;
      r_pc_src     <= PC_4;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_reg_dst    <= RD_RT;
      r_ext_sel    <= 1'b0;
      r_op_sel     <= ALU_ADD;
      r_b_src      <= 1'b0;
      r_wb_src     <= WB_ALU;
      r_com_format <= FMT_R;
      r_err        <= 1'b0;
    end else begin
      // Strobes default low; only the entered state raises them.
      r_pc_en     <= 1'b0;
      r_ir_en     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_req   <= 1'b0;
      r_pc_src    <= PC_4;
      r_wb_src    <= WB_ALU;
      r_halted    <= 1'b0;

      case (r_state)
        ST_HALT: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_ir_en <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_halted <= 1'b1;
          end
        end

        ST_FETCH: r_state <= ST_DECODE;

        ST_DECODE: begin
          r_opcode <= OpCode;
          if (w_illegal) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_state      <= ST_EXEC;
            r_com_format <= w_ctrl.com_format;
            r_ext_sel    <= w_ctrl.ext_sel;
            r_reg_dst    <= w_ctrl.reg_dst;
            r_b_src      <= w_ctrl.b_src;
            r_op_sel     <= w_ctrl.op_sel;
            r_wb_sel     <= w_ctrl.wb_src;
            // Branches and j retire in EXEC, so their PC load is set up here.
            if ((OpCode == OP_BEQ) || (OpCode == OP_BNE)) begin
              r_pc_en  <= 1'b1;
              r_pc_src <= branch_taken(OpCode, zero) ? PC_BR : PC_4;
            end else if (OpCode == OP_J) begin
              r_pc_en  <= 1'b1;
              r_pc_src <= PC_JMP;
            end
          end
        end

        ST_EXEC: begin
          if ((r_opcode == OP_BEQ) || (r_opcode == OP_BNE) || (r_opcode == OP_J)) begin
            r_state <= ST_FETCH;
            r_ir_en <= 1'b1;
          end else if ((r_opcode == OP_LW) || (r_opcode == OP_SW)) begin
            r_state     <= ST_MEM;
            r_mem_req   <= 1'b1;
            r_mem_write <= (r_opcode == OP_SW);
            r_cnt       <= '0;
          end else begin
            r_state     <= ST_WB;
            r_reg_write <= 1'b1;
            r_pc_en     <= 1'b1;
            r_pc_src    <= (r_opcode == OP_JAL) ? PC_JMP : PC_4;
            r_wb_src    <= r_wb_sel;
          end
        end

        ST_MEM: begin
          if (mem_ready) begin
            r_cnt <= '0;
            if (r_opcode == OP_SW) begin
              r_state <= ST_FETCH;
              r_ir_en <= 1'b1;
              r_pc_en <= 1'b1;
            end else begin
              r_state     <= ST_WB;
              r_reg_write <= 1'b1;
              r_pc_en     <= 1'b1;
              r_wb_src    <= r_wb_sel;
            end
          end else if (w_timeout_hit) begin
            r_cnt    <= '0;
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            if (MEM_TIMEOUT != 0) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            r_mem_req   <= 1'b1;
            r_mem_write <= (r_opcode == OP_SW);
          end
        end

        ST_WB: begin
          r_state <= ST_FETCH;
          r_ir_en <= 1'b1;
        end

        default: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
          r_err    <= 1'b1;
        end
      endcase
    end
  end

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_instr;

  // Activity counters: non-HALT cycles and retired instructions; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_instr  <= '0;
    end else begin
      if (r_state != ST_HALT) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if (r_pc_en) begin
        r_perf_instr <= r_perf_instr + 32'd1;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_instr  = r_perf_instr;
`endif

  assign pc_en     = r_pc_en;
  assign ir_en     = r_ir_en;
  assign PCSrc     = r_pc_src;
  assign RegWrite  = r_reg_write;
  assign MemWrite  = r_mem_write;
  assign mem_req   = r_mem_req;
  assign RegDst    = r_reg_dst;
  assign ExtSel    = r_ext_sel;
  assign OpSel     = r_op_sel;
  assign BSrc      = r_b_src;
  assign WBSrc     = r_wb_src;
  assign comFormat = r_com_format;
  assign halted    = r_halted;
  assign err       = r_err;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: retire-record scoreboard plus latency and state checks.
module tb_cpu_ctrl_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  OpCode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic        ir_en;
  logic [1:0]  PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic        mem_req;
  logic [1:0]  RegDst;
  logic        ExtSel;
  logic [3:0]  OpSel;
  logic        BSrc;
  logic [1:0]  WBSrc;
  logic [1:0]  comFormat;
  logic        halted;
  logic        err;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_instr;
`endif

  cpu_ctrl_seq #(.MEM_TIMEOUT(16), .RESET_HALT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .OpCode    (OpCode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .ir_en     (ir_en),
    .PCSrc     (PCSrc),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .mem_req   (mem_req),
    .RegDst    (RegDst),
    .ExtSel    (ExtSel),
    .OpSel     (OpSel),
    .BSrc      (BSrc),
    .WBSrc     (WBSrc),
    .comFormat (comFormat),
    .halted    (halted),
    .err       (err)
`ifdef CPU_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_instr  (perf_instr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected controls at the pc_en pulse of one instruction; -1 means not checked.
  typedef struct {
    string tag;
    int    pcs;
    int    rw;
    int    wb;
    int    rd;
    int    ext;
    int    bs;
    int    op;
    int    fmt;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int pcs, input int rw, input int wb, input int rd,
                      input int ext, input int bs, input int op, input int fmt);
    exp_t e;
    e.tag = tag; e.pcs = pcs; e.rw = rw; e.wb = wb; e.rd = rd;
    e.ext = ext; e.bs = bs; e.op = op; e.fmt = fmt;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled on the falling edge and retire pulses scored.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (RegWrite === 1'b1) chk("regwrite_needs_pc_en", 32'(pc_en), 32'd1);
    if (MemWrite === 1'b1) chk("memwrite_needs_req", 32'(mem_req), 32'd1);
    if (pc_en === 1'b1) begin
      chk("pc_en_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.pcs >= 0) chk({e.tag, ".PCSrc"},     32'(PCSrc),     32'(e.pcs));
        if (e.rw  >= 0) chk({e.tag, ".RegWrite"},  32'(RegWrite),  32'(e.rw));
        if (e.wb  >= 0) chk({e.tag, ".WBSrc"},     32'(WBSrc),     32'(e.wb));
        if (e.rd  >= 0) chk({e.tag, ".RegDst"},    32'(RegDst),    32'(e.rd));
        if (e.ext >= 0) chk({e.tag, ".ExtSel"},    32'(ExtSel),    32'(e.ext));
        if (e.bs  >= 0) chk({e.tag, ".BSrc"},      32'(BSrc),      32'(e.bs));
        if (e.op  >= 0) chk({e.tag, ".OpSel"},     32'(OpSel),     32'(e.op));
        if (e.fmt >= 0) chk({e.tag, ".comFormat"}, 32'(comFormat), 32'(e.fmt));
      end
    end
  endtask

  // Run until the next FETCH (ir_en) or HALT, bounded by limit.
  // ready_after: -1 leave mem_ready alone, 0 hold it low, n raise it in the nth MEM cycle.
  task automatic run(input int ready_after, input int limit,
                     output int lat, output int req, output int mw, output int rw);
    lat = 0; req = 0; mw = 0; rw = 0;
    if (ready_after >= 0) mem_ready = 1'b0;
    do begin
      cyc();
      lat++;
      if (RegWrite === 1'b1) rw++;
      if (mem_req === 1'b1) begin
        req++;
        if (MemWrite === 1'b1) mw++;
      end
      if (ready_after > 0 && req >= ready_after) mem_ready = 1'b1;
    end while (ir_en !== 1'b1 && halted !== 1'b1 && lat < limit);
  endtask

  int lat, req, mw, rw;
  int n;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; OpCode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    cyc();
    cyc();
    chk("rst.pc_en",     32'(pc_en),     32'd0);
    chk("rst.ir_en",     32'(ir_en),     32'd0);
    chk("rst.mem_req",   32'(mem_req),   32'd0);
    chk("rst.halted",    32'(halted),    32'd0);
    chk("rst.err",       32'(err),       32'd0);
    chk("rst.PCSrc",     32'(PCSrc),     32'd0);
    chk("rst.OpSel",     32'(OpSel),     32'd0);
    chk("rst.comFormat", 32'(comFormat), 32'd0);

    // addi from reset: DECODE, EXEC, WB, FETCH
    rst = 1'b0; OpCode = 6'b001000; mem_ready = 1'bx;
    push("addi", 0, 1, 0, 0, 1, 1, 0, 1);
    run(-1, 10, lat, req, mw, rw);
    chk("addi.latency", 32'(lat), 32'd4);
    chk("addi.rw_count", 32'(rw), 32'd1);

    // beq / bne with both zero values
    OpCode = 6'b000100; zero = 1'b1;
    push("beq_z1", 1, 0, -1, -1, -1, 0, 1, 1);
    run(-1, 10, lat, req, mw, rw);
    chk("beq_z1.latency", 32'(lat), 32'd3);
    zero = 1'b0;
    push("beq_z0", 0, 0, -1, -1, -1, 0, 1, 1);
    run(-1, 10, lat, req, mw, rw);
    chk("beq_z0.latency", 32'(lat), 32'd3);
    OpCode = 6'b000101; zero = 1'b0;
    push("bne_z0", 1, 0, -1, -1, -1, 0, 1, 1);
    run(-1, 10, lat, req, mw, rw);
    zero = 1'b1;
    push("bne_z1", 0, 0, -1, -1, -1, 0, 1, 1);
    run(-1, 10, lat, req, mw, rw);
    chk("bne_z1.latency", 32'(lat), 32'd3);

    // j
    OpCode = 6'b000010;
    push("j", 2, 0, -1, -1, -1, -1, -1, 2);
    run(-1, 10, lat, req, mw, rw);
    chk("j.latency", 32'(lat), 32'd3);

    // lw with mem_ready low for 3 MEM cycles
    OpCode = 6'b100011;
    push("lw", 0, 1, 1, 0, 1, 1, 0, 1);
    run(4, 20, lat, req, mw, rw);
    chk("lw.latency", 32'(lat), 32'd8);
    chk("lw.mem_req_cycles", 32'(req), 32'd4);
    chk("lw.memwrite_cycles", 32'(mw), 32'd0);

    // sw completing on the second MEM cycle
    OpCode = 6'b101011;
    push("sw", 0, 0, -1, -1, 1, 1, 0, 1);
    run(2, 20, lat, req, mw, rw);
    chk("sw.latency", 32'(lat), 32'd5);
    chk("sw.memwrite_cycles", 32'(mw), 32'd2);
    chk("sw.rw_count", 32'(rw), 32'd0);

    // sw with memory never ready: timeout after 16 waiting cycles
    OpCode = 6'b101011;
    run(0, 40, lat, req, mw, rw);
    chk("sw_to.latency", 32'(lat), 32'd19);
    chk("sw_to.mem_req_cycles", 32'(req), 32'd16);
    chk("sw_to.halted", 32'(halted), 32'd1);
    chk("sw_to.err", 32'(err), 32'd1);
    chk("sw_to.MemWrite", 32'(MemWrite), 32'd0);
    chk("sw_to.mem_req", 32'(mem_req), 32'd0);
    cyc();
    chk("sw_to.still_halted", 32'(halted), 32'd1);
    chk("sw_to.err_sticky", 32'(err), 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start.ir_en", 32'(ir_en), 32'd1);
    chk("start.err_clear", 32'(err), 32'd0);
    chk("start.halted", 32'(halted), 32'd0);

    // illegal opcode
    OpCode = 6'b111111;
    run(-1, 10, lat, req, mw, rw);
    chk("illegal.latency", 32'(lat), 32'd2);
    chk("illegal.halted", 32'(halted), 32'd1);
    chk("illegal.err", 32'(err), 32'd1);
    chk("illegal.rw_count", 32'(rw), 32'd0);
    chk("illegal.mw_count", 32'(mw), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart.ir_en", 32'(ir_en), 32'd1);

    // rst during a lw memory wait
    OpCode = 6'b100011; mem_ready = 1'b0;
    n = 0; req = 0;
    while (req < 2 && n < 10) begin
      cyc();
      n++;
      if (mem_req === 1'b1) req++;
    end
    chk("midrst.reached_mem", 32'(req), 32'd2);
    rst = 1'b1;
    cyc();
    chk("midrst.mem_req", 32'(mem_req), 32'd0);
    chk("midrst.pc_en", 32'(pc_en), 32'd0);
    chk("midrst.halted", 32'(halted), 32'd0);
`ifdef CPU_CTRL_PERF_EN
    chk("midrst.perf_instr", perf_instr, 32'd0);
`endif

    // jal straight out of reset proves the sequencer restarted in FETCH
    rst = 1'b0; OpCode = 6'b000011;
    push("jal", 2, 1, 2, 2, -1, -1, -1, 2);
    run(-1, 10, lat, req, mw, rw);
    chk("jal.latency", 32'(lat), 32'd4);
`ifdef CPU_CTRL_PERF_EN
    chk("jal.perf_instr", perf_instr, 32'd1);
`endif

    // R-type
    OpCode = 6'b000000;
    push("rtype", 0, 1, 0, 1, -1, 0, 15, 0);
    run(-1, 10, lat, req, mw, rw);
    chk("rtype.latency", 32'(lat), 32'd4);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
